// File: rtl/ffa_fifo_reader_pkg.sv
// Shared definitions for the ffa FIFO read-side master: default widths,
// FSM state encodings and the pop-credit helper.
package ffa_fifo_reader_pkg;

    localparam int FW_DEF = 16;
    localparam int CW_DEF = 8;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_POP   = 2'd1,
        RD_DRAIN = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_t;

    // Words that will sit in the skid buffer after this edge:
    // current occupancy, minus the word handed off now, plus the word in flight.
    function automatic logic [2:0] pipe_load(input logic [1:0] occ,
                                             input logic       handoff,
                                             input logic       inflight);
        return {1'b0, occ} - {2'b00, handoff} + {2'b00, inflight};
    endfunction

endpackage

// File: rtl/ffa_fifo_reader_if.sv
// Burst-request, FIFO read and downstream valid/ready signals of the
// ffa FIFO reader. rd_xsum exists only when FFA_READER_XSUM_EN is defined.
interface ffa_fifo_reader_if #(
    parameter int FW = 16,
    parameter int CW = 8
) ();
    logic          rd_req;
    logic [CW-1:0] rd_len;
    logic          rd_busy;
    logic          rd_done;
    logic          fifo_pop;
    logic          fifo_not_ready;
    logic [FW-1:0] fifo_data;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_data;
    logic [CW-1:0] out_idx;
`ifdef FFA_READER_XSUM_EN
    logic [FW-1:0] rd_xsum;
`endif

    modport master (
        input  rd_req, rd_len, fifo_not_ready, fifo_data, out_ready,
        output rd_busy, rd_done, fifo_pop, out_valid, out_data, out_idx
`ifdef FFA_READER_XSUM_EN
        , output rd_xsum
`endif
    );

    modport slave (
        output rd_req, rd_len, fifo_not_ready, fifo_data, out_ready,
        input  rd_busy, rd_done, fifo_pop, out_valid, out_data, out_idx
`ifdef FFA_READER_XSUM_EN
        , input rd_xsum
`endif
    );
endinterface

// File: rtl/ffa_fifo_reader_skid2.sv
// Two-entry in-order buffer that absorbs the FIFO pop->data latency.
// Entry 0 is always the head; reads with occ==0 are ignored.
module ffa_fifo_reader_skid2 #(
    parameter int FW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [FW-1:0] wr_data,
    input  logic          rd_en,
    output logic [FW-1:0] rd_data,
    output logic [1:0]    occ
);
    logic [FW-1:0] mem0;
    logic [FW-1:0] mem1;
    logic          do_rd;

    assign do_rd   = rd_en && (occ != 2'd0);
    assign rd_data = mem0;

    // Shift/fill the two entries; simultaneous write and read keeps occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem0 <= '0;
            mem1 <= '0;
            occ  <= 2'd0;
        end else begin
            case ({wr_en, do_rd})
                2'b10: begin
                    if (occ == 2'd0) mem0 <= wr_data;
                    else             mem1 <= wr_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    mem0 <= mem1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        mem0 <= wr_data;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/ffa_fifo_reader.sv
// Read-side master for the 3-entry ffa FIFO. Pops a burst of rd_len words,
// absorbs the 1-cycle pop->data latency in a 2-entry skid buffer and forwards
// the words on a valid/ready port with a 0-based index.
// Optional feature macro: FFA_READER_XSUM_EN adds rd_xsum, the XOR of all
// words handed off in the burst.
//
// state    | meaning
// RD_IDLE  | waiting for rd_req
// RD_POP   | popping the FIFO, words still to request
// RD_DRAIN | all pops issued, handing off remaining words
// RD_DONE  | one-cycle rd_done pulse
module ffa_fifo_reader
    import ffa_fifo_reader_pkg::*;
#(
    parameter int FW = FW_DEF,
    parameter int CW = CW_DEF
) (
    input logic               clk,
    input logic               reset,
    ffa_fifo_reader_if.master bus
);
    rd_state_t     state;
    logic [CW-1:0] pops_left;
    logic [CW-1:0] last_idx;
    logic [CW-1:0] out_idx;
    logic          inflight;
    logic          rd_busy_r;
    logic          rd_done_r;

    logic [1:0]    skid_occ;
    logic [FW-1:0] skid_data;
    logic          out_valid;
    logic          handoff;
    logic          fifo_pop;

    assign out_valid = (skid_occ != 2'd0);
    assign handoff   = out_valid && bus.out_ready;

    // The word handed off this cycle frees its slot at the same edge, which is
    // what lets the burst stream at one word per cycle with out_ready high;
    // under backpressure pops stop once two words are buffered or in flight.
    assign fifo_pop = (state == RD_POP) && !bus.fifo_not_ready &&
                      (pops_left != '0) &&
                      (pipe_load(skid_occ, handoff, inflight) < 3'd2);

    ffa_fifo_reader_skid2 #(.FW(FW)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (inflight),
        .wr_data (bus.fifo_data),
        .rd_en   (handoff),
        .rd_data (skid_data),
        .occ     (skid_occ)
    );

    // Burst FSM with pop counter, in-flight flag, word index and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RD_IDLE;
            pops_left <= '0;
            last_idx  <= '0;
            out_idx   <= '0;
            inflight  <= 1'b0;
            rd_busy_r <= 1'b0;
            rd_done_r <= 1'b0;
        end else begin
            inflight <= fifo_pop;
            if (handoff) out_idx <= out_idx + CW'(1);
            case (state)
                RD_IDLE: begin
                    if (bus.rd_req) begin
                        out_idx   <= '0;
                        pops_left <= bus.rd_len;
                        last_idx  <= bus.rd_len - CW'(1);
                        if (bus.rd_len != '0) begin
                            state     <= RD_POP;
                            rd_busy_r <= 1'b1;
                        end else begin
                            state     <= RD_DONE;
                            rd_done_r <= 1'b1;
                        end
                    end
                end
                RD_POP: begin
                    if (fifo_pop) begin
                        pops_left <= pops_left - CW'(1);
                        if (pops_left == CW'(1)) state <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (handoff && out_idx == last_idx) begin
                        state     <= RD_DONE;
                        rd_busy_r <= 1'b0;
                        rd_done_r <= 1'b1;
                    end
                end
                RD_DONE: begin
                    state     <= RD_IDLE;
                    rd_done_r <= 1'b0;
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

`ifdef FFA_READER_XSUM_EN
    logic [FW-1:0] xsum;

    // Running XOR of handed-off words, restarted on every accepted rd_req.
    always_ff @(posedge clk) begin
        if (reset) begin
            xsum <= '0;
        end else if (state == RD_IDLE && bus.rd_req) begin
            xsum <= '0;
        end else if (handoff) begin
            xsum <= xsum ^ skid_data;
        end
    end

    assign bus.rd_xsum = xsum;
`endif

    assign bus.fifo_pop  = fifo_pop;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = skid_data;
    assign bus.out_idx   = out_idx;
    assign bus.rd_busy   = rd_busy_r;
    assign bus.rd_done   = rd_done_r;
endmodule
